// File: rtl/load_ctrl_if.sv
// Handshake and bus bundle between the load sequencer and its instruction source, register file and data RAM.
// The master side is the sequencer; the slave side is the surrounding pipeline and memory.
interface load_ctrl_if #(
  parameter int XPRLEN = 32,
  parameter int ADDR_W = 8
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic [4:0]        rs1_idx;
  logic [XPRLEN-1:0] rs1_data;
  logic              mem_rden;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              wb_en;
  logic [4:0]        wb_idx;
  logic [XPRLEN-1:0] wb_data;
  logic              illegal;
  logic              misalign;
  logic              busy;

  modport master (
    input  instr_valid, instr, rs1_data, mem_rdata,
    output instr_ready, rs1_idx, mem_rden, mem_addr, wb_en, wb_idx, wb_data,
           illegal, misalign, busy
  );

  modport slave (
    output instr_valid, instr, rs1_data, mem_rdata,
    input  instr_ready, rs1_idx, mem_rden, mem_addr, wb_en, wb_idx, wb_data,
           illegal, misalign, busy
  );
endinterface

// File: rtl/load_ctrl.sv
// Load sequencer: one load in flight, RAM read at accept+1, wb_en at accept+2+MEM_LAT, faults pulse at accept+1.
// Backpressure: instr_ready only in IDLE; RAM and register write port are never stalled.
module load_ctrl #(
  parameter int XPRLEN  = 32,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input logic         clk,
  input logic         rst,
  load_ctrl_if.master bus
);
  localparam int         CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
  } instr_t;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, WB} state_t;

  state_t            state_q, state_d;
  instr_t            iw;
  logic              accept;
  logic [4:0]        rd_q;
  logic [2:0]        f3_q;
  logic [6:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XPRLEN-1:0] result_q;
  logic [XPRLEN-1:0] ext_d;
  logic [XPRLEN-1:0] imm_sext;
  logic [31:0]       shifted;
  logic              bad_op, bad_align;
  logic              rden_c, wb_c, ill_c, mis_c;

  assign iw       = instr_t'(bus.instr);
  assign accept   = bus.instr_valid & bus.instr_ready;
  assign imm_sext = {{(XPRLEN-12){iw.imm[11]}}, iw.imm};

  // LD (011), LWU (110) and 111 are rejected; opcode check takes priority over alignment.
  assign bad_op    = (op_q != OP_LOAD) || (f3_q == 3'b011) || (f3_q[2:1] == 2'b11);
  assign bad_align = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rden_c  = 1'b0;
    wb_c    = 1'b0;
    ill_c   = 1'b0;
    mis_c   = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = ADDR;
      ADDR: begin
        if (bad_op) begin
          ill_c   = 1'b1;
          state_d = IDLE;
        end else if (bad_align) begin
          mis_c   = 1'b1;
          state_d = IDLE;
        end else begin
          rden_c  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == '0) state_d = WB;
      WB: begin
        wb_c    = (rd_q != 5'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Alignment is guaranteed by now, so one byte-granular shift serves byte, half and word lanes.
  always_comb begin
    shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    ext_d   = XPRLEN'(shifted);
    case (f3_q)
      3'b000:  ext_d = {{(XPRLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext_d = {{(XPRLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ext_d = {{(XPRLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ext_d = {{(XPRLEN-16){1'b0}}, shifted[15:0]};
      default: ext_d = XPRLEN'(shifted);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      f3_q     <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rd_q   <= iw.rd;
        f3_q   <= iw.funct3;
        op_q   <= iw.opcode;
        addr_q <= ADDR_W'(bus.rs1_data + imm_sext);
      end
      if (rden_c) begin
        cnt_q <= CNT_W'(MEM_LAT - 1);
      end else if (state_q == WAIT) begin
        if (cnt_q == '0) result_q <= ext_d;
        else             cnt_q    <= cnt_q - 1'b1;
      end
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.rs1_idx     = iw.rs1;
  assign bus.mem_rden    = rden_c;
  assign bus.mem_addr    = addr_q;
  assign bus.wb_en       = wb_c;
  assign bus.wb_idx      = rd_q;
  assign bus.wb_data     = result_q;
  assign bus.illegal     = ill_c;
  assign bus.misalign    = mis_c;
endmodule

// File: tb/tb_load_ctrl.sv
// Bench for load_ctrl: directed loads from the RAM word 0x80FF7F01 plus randomized loads checked
// against an arithmetic reference model, handshake spacing and mid-operation reset.
module tb_load_ctrl;
  localparam int XPRLEN  = 32;
  localparam int ADDR_W  = 8;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_ctrl_if #(.XPRLEN(XPRLEN), .ADDR_W(ADDR_W)) bus ();

  load_ctrl #(.XPRLEN(XPRLEN), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] regs [32];
  logic [31:0] ram  [64];
  logic [31:0] pipe [MEM_LAT];

  assign bus.rs1_data  = regs[bus.rs1_idx];
  assign bus.mem_rdata = pipe[MEM_LAT-1];

  // RAM with MEM_LAT-cycle read latency; garbage on idle cycles exposes early sampling.
  always @(posedge clk) begin
    pipe[0] <= bus.mem_rden ? ram[bus.mem_addr[ADDR_W-1:2]] : $urandom;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [11:0] imm, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {rd, rs1, imm, f3, op};
  endfunction

  // Reference: kind 0 = legal, 1 = illegal, 2 = misaligned.
  function automatic void model(input logic [31:0] iw, input logic [31:0] rs1v,
                                output int kind, output logic [31:0] ea, output logic [31:0] res);
    int unsigned op, f3, imm, a, b, word, byt, half;
    int          simm;
    op   = iw[6:0];
    f3   = iw[9:7];
    imm  = iw[21:10];
    simm = (imm >= 2048) ? int'(imm) - 4096 : int'(imm);
    ea   = rs1v + 32'(simm);
    a    = ea % 256;
    b    = a % 4;
    word = ram[a / 4];
    byt  = (word >> (8 * b)) & 255;
    half = (word >> (16 * (b / 2))) & 65535;
    res  = 0;
    if (op != 3 || f3 == 3 || f3 == 6 || f3 == 7) kind = 1;
    else if (((f3 == 1 || f3 == 5) && (ea % 2) != 0) || (f3 == 2 && (ea % 4) != 0)) kind = 2;
    else kind = 0;
    case (f3)
      0: res = (byt >= 128) ? 32'(byt) - 32'd256 : 32'(byt);
      1: res = (half >= 32768) ? 32'(half) - 32'd65536 : 32'(half);
      2: res = word;
      4: res = byt;
      5: res = half;
      default: res = 0;
    endcase
  endfunction

  task automatic run_load(input string tag, input logic [31:0] iw, output logic [31:0] wb_obs);
    int          kind;
    logic [31:0] ea, res;
    logic [31:0] addr_obs = 0;
    logic [31:0] idx_obs  = 0;
    logic [4:0]  rd = iw[31:27];
    int rden_k = 0, wb_k = 0, ill_k = 0, mis_k = 0, rdy_k = 0;
    int n_rden = 0, n_wb = 0, n_ill = 0, n_mis = 0, busy_bad = 0;
    wb_obs = 0;
    model(iw, regs[iw[26:22]], kind, ea, res);
    @(negedge clk);
    bus.instr       = iw;
    bus.instr_valid = 1'b1;
    check({tag, ".ready_T"}, 32'(bus.instr_ready), 1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    for (int k = 1; k <= MEM_LAT + 6; k++) begin
      @(negedge clk);
      if (bus.mem_rden) begin
        n_rden++;
        if (rden_k == 0) begin rden_k = k; addr_obs = 32'(bus.mem_addr); end
      end
      if (bus.wb_en) begin
        n_wb++;
        if (wb_k == 0) begin wb_k = k; wb_obs = bus.wb_data; idx_obs = 32'(bus.wb_idx); end
      end
      if (bus.illegal)  begin n_ill++; if (ill_k == 0) ill_k = k; end
      if (bus.misalign) begin n_mis++; if (mis_k == 0) mis_k = k; end
      if (bus.instr_ready && rdy_k == 0) rdy_k = k;
      if (bus.busy == bus.instr_ready) busy_bad++;
    end
    check({tag, ".busy"}, busy_bad, 0);
    if (kind == 0) begin
      check({tag, ".rden_cyc"}, rden_k, 1);
      check({tag, ".rden_cnt"}, n_rden, 1);
      check({tag, ".addr"}, addr_obs, 32'(ea[ADDR_W-1:0]));
      check({tag, ".faults"}, n_ill + n_mis, 0);
      check({tag, ".wb_cnt"}, n_wb, (rd != 0) ? 1 : 0);
      if (rd != 0) begin
        check({tag, ".wb_cyc"}, wb_k, 2 + MEM_LAT);
        check({tag, ".wb_data"}, wb_obs, res);
        check({tag, ".wb_idx"}, idx_obs, 32'(rd));
      end
      check({tag, ".ready_cyc"}, rdy_k, 3 + MEM_LAT);
    end else begin
      check({tag, ".ill_cyc"}, ill_k, (kind == 1) ? 1 : 0);
      check({tag, ".mis_cyc"}, mis_k, (kind == 2) ? 1 : 0);
      check({tag, ".pulses"}, n_ill + n_mis, 1);
      check({tag, ".no_rden"}, n_rden, 0);
      check({tag, ".no_wb"}, n_wb, 0);
      check({tag, ".ready_cyc"}, rdy_k, 2);
    end
  endtask

  task automatic back_to_back();
    int acc_k [3];
    int n_acc = 0, busy_bad = 0, nwb = 0;
    foreach (acc_k[i]) acc_k[i] = 0;
    bus.instr = enc(5'd6, 5'd2, 12'd0, 3'b010, 7'h03);
    for (int k = 0; k < 40 && n_acc < 3; k++) begin
      @(negedge clk);
      if (k == 0) bus.instr_valid = 1'b1;
      if (bus.wb_en) nwb++;
      if (bus.instr_ready) begin acc_k[n_acc] = k; n_acc++; end
      else if (!bus.busy) busy_bad++;
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    for (int k = 0; k < 3 * MEM_LAT + 6; k++) begin
      @(negedge clk);
      if (bus.wb_en) nwb++;
    end
    check("b2b.accepts", n_acc, 3);
    check("b2b.gap1", acc_k[1] - acc_k[0], 3 + MEM_LAT);
    check("b2b.gap2", acc_k[2] - acc_k[1], 3 + MEM_LAT);
    check("b2b.busy", busy_bad, 0);
    check("b2b.wb_cnt", nwb, 3);
  endtask

  task automatic reset_mid_op();
    int bad = 0;
    @(negedge clk);
    bus.instr       = enc(5'd7, 5'd2, 12'd0, 3'b010, 7'h03);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstmid.busy", 32'(bus.busy), 0);
    check("rstmid.wb_data", bus.wb_data, 0);
    check("rstmid.mem_addr", 32'(bus.mem_addr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < MEM_LAT + 6; k++) begin
      @(negedge clk);
      if (k == 0) check("rstmid.ready", 32'(bus.instr_ready), 1);
      if (bus.wb_en || bus.illegal || bus.misalign || bus.mem_rden) bad++;
    end
    check("rstmid.quiet", bad, 0);
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] iw;
    logic [6:0]  op;
    foreach (regs[i]) regs[i] = 0;
    foreach (ram[i])  ram[i]  = $urandom;
    ram[4]          = 32'h80FF7F01;
    regs[2]         = 32'h10;
    regs[3]         = 32'h05;
    regs[4]         = 32'hFF;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;

    @(negedge clk);
    check("rst.ready", 32'(bus.instr_ready), 1);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.rden", 32'(bus.mem_rden), 0);
    check("rst.addr", 32'(bus.mem_addr), 0);
    check("rst.wb_en", 32'(bus.wb_en), 0);
    check("rst.wb_idx", 32'(bus.wb_idx), 0);
    check("rst.wb_data", bus.wb_data, 0);
    check("rst.illegal", 32'(bus.illegal), 0);
    check("rst.misalign", 32'(bus.misalign), 0);
    @(negedge clk);
    rst = 1'b0;

    run_load("lb3", enc(5'd5, 5'd2, 12'd3, 3'b000, 7'h03), obs);  check("lb3.val", obs, 32'hFFFFFF80);
    run_load("lbu3", enc(5'd6, 5'd2, 12'd3, 3'b100, 7'h03), obs); check("lbu3.val", obs, 32'h00000080);
    run_load("lb1", enc(5'd7, 5'd2, 12'd1, 3'b000, 7'h03), obs);  check("lb1.val", obs, 32'h0000007F);
    run_load("lh2", enc(5'd8, 5'd2, 12'd2, 3'b001, 7'h03), obs);  check("lh2.val", obs, 32'hFFFF80FF);
    run_load("lhu2", enc(5'd9, 5'd2, 12'd2, 3'b101, 7'h03), obs); check("lhu2.val", obs, 32'h000080FF);
    run_load("lw0", enc(5'd31, 5'd2, 12'd0, 3'b010, 7'h03), obs); check("lw0.val", obs, 32'h80FF7F01);
    run_load("neg_imm", enc(5'd10, 5'd3, 12'hFFF, 3'b000, 7'h03), obs);
    run_load("wrap", enc(5'd11, 5'd4, 12'd1, 3'b000, 7'h03), obs);
    run_load("op23", enc(5'd12, 5'd2, 12'd0, 3'b010, 7'h23), obs);
    run_load("ld", enc(5'd12, 5'd2, 12'd0, 3'b011, 7'h03), obs);
    run_load("lh_mis", enc(5'd13, 5'd2, 12'd1, 3'b001, 7'h03), obs);
    run_load("lw_mis", enc(5'd14, 5'd2, 12'd2, 3'b010, 7'h03), obs);
    run_load("rd0", enc(5'd0, 5'd2, 12'd0, 3'b010, 7'h03), obs);

    back_to_back();
    reset_mid_op();
    run_load("post_rst", enc(5'd15, 5'd2, 12'd3, 3'b000, 7'h03), obs);
    check("post_rst.val", obs, 32'hFFFFFF80);

    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h03;
      iw = enc(5'($urandom), 5'($urandom), 12'($urandom), 3'($urandom), op);
      run_load("rand", iw, obs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/load_ctrl.md
# load_ctrl

Load sequencer that sits directly upstream of the byte-load unit and the data RAM. It accepts one decoded memory-class instruction word at a time and reads rs1 from the register file. It computes the effective address, issues a single RAM read and sign- or zero-extends the returned word per funct3. The result is then written to rd through the register-file write port. It covers LB/LH/LW/LBU/LHU and flags illegal and misaligned loads.

## Interface
- XPRLEN, 32, register width.
- ADDR_W, 8, data RAM byte-address width; RAM is 32 bits wide, word index = addr[ADDR_W-1:2].
- MEM_LAT, 2, RAM read latency in cycles, ≥1.

- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction word present.
- instr  in  32  fields: [31:27] rd, [26:22] rs1, [21:17] imm[11:7], [16:10] imm[6:0], [9:7] funct3, [6:0] opcode.
- instr_ready  out  1  high only in IDLE; accept = instr_valid & instr_ready.
- rs1_idx  out  5  register-file read index, = instr[26:22] combinationally.
- rs1_data  in  XPRLEN  register-file read data, valid in the same cycle as rs1_idx.
- mem_rden  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  registered byte address.
- mem_rdata  in  32  RAM word, valid MEM_LAT cycles after the mem_rden cycle.
- wb_en  out  1  one-cycle register write strobe.
- wb_idx  out  5  destination register.
- wb_data  out  XPRLEN  extended load result.
- illegal  out  1  one-cycle pulse for a bad opcode or funct3.
- misalign  out  1  one-cycle pulse for a misaligned address.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ADDR, WAIT, WB.
- IDLE:
  - On accept, register rd, funct3 and ea = rs1_data + sext(imm12), computed modulo 2^XPRLEN.
  - sext(imm12) sign-extends from instr[21].
  - Go to ADDR.
- ADDR, illegal case: opcode ≠ 7'b0000011, or funct3 ∈ {011 LD, 110 LWU, 111}.
  - Pulse illegal.
  - No mem_rden, no wb_en.
  - Next state IDLE.
- ADDR, misaligned case: LH/LHU with ea[0]=1, or LW with ea[1:0]≠0.
  - Pulse misalign.
  - No mem_rden, no wb_en.
  - Next state IDLE.
- ADDR, legal case: assert mem_rden with mem_addr = ea[ADDR_W-1:0] (upper bits dropped, address wraps); load a counter with MEM_LAT-1; go to WAIT.
- Illegal is checked before misalign; at most one of the two pulses per instruction.
- WAIT: decrement the counter. When the counter is 0, capture the extracted and extended data from mem_rdata, then go to WB.
- Lane extraction is little-endian:
  - byte = mem_rdata[8*ea[1:0] +: 8]
  - half = mem_rdata[16*ea[1] +: 16]
- Extension by funct3:
  - LB / LH: sign-extend to XPRLEN.
  - LBU / LHU: zero-extend to XPRLEN.
  - LW: whole word.
- WB: wb_en=1 for exactly one cycle, with wb_idx = rd and wb_data = result; next state IDLE.
- rd = 0: the read is still performed, but wb_en stays 0 in WB.
- instr_valid outside IDLE is ignored; the instruction must be held until accepted.

## Timing
- Reset values: state IDLE, so instr_ready=1 and busy=0. mem_rden, mem_addr, wb_en, wb_idx, wb_data, illegal and misalign are all 0.
- Accepts are ignored while rst is high.
- Legal load accepted in cycle T:
  - mem_rden in T+1.
  - mem_rdata sampled in T+1+MEM_LAT.
  - wb_en in T+2+MEM_LAT.
  - instr_ready high again in T+3+MEM_LAT.
- Default timing (MEM_LAT=2): wb_en in T+4, next accept no earlier than T+5.
- Illegal or misaligned instruction: pulse in T+1, instr_ready in T+2.
- rst asserted mid-operation: immediate return to IDLE with all outputs cleared. A pending write is dropped, and no pulse is emitted after reset.

## Test plan
- Byte loads: RAM word at addr 0x10 = 0x80FF7F01; rs1=x2=0x10; LB imm=3 -> wb_data=0xFFFFFF80 at T+4; LBU imm=3 -> 0x00000080; LB imm=1 -> 0x0000007F.
- Halfword and word loads: same word, LH imm=2 -> wb_data=0xFFFF80FF; LHU imm=2 -> 0x000080FF; LW imm=0 -> 0x80FF7F01; wb_idx equals rd.
- Address arithmetic: rs1=0x05, imm=0xFFF (-1) -> mem_addr=0x04. rs1=0xFF, imm=1 -> mem_addr=0x00 (wraps).
- Illegal and misaligned: opcode 0x23 -> illegal pulse at T+1, no mem_rden. funct3=011 -> illegal. LH at addr 0x11 -> misalign at T+1. LW at 0x12 -> misalign. No wb_en in any of these cases.
- Handshake: hold instr_valid for 3 back-to-back loads -> accepts at T, T+5, T+10; busy high in between. A rd=0 load -> mem_rden seen, wb_en never asserted.
- Reset mid-op: assert rst at T+2 of a load -> wb_en never rises, instr_ready=1 right after release, and the next load completes normally.
